// File: rtl/victim_wb_buffer.sv
// N-way victim select (one-hot LRU) feeding a writeback FIFO drained through a valid/ready port.
// Optional macro VICTIM_SNOOP_EN adds a combinational snoop lookup over the queued entries.
module victim_wb_buffer #(
  parameter int WAYS   = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 7,
  parameter int DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     evict_req,
  output logic                     evict_ready,
  input  logic [WAYS-1:0]          lru,
  input  logic [WAYS-1:0]          dirty,
  input  logic [WAYS*DATA_W-1:0]   way_data,
  input  logic [WAYS*TAG_W-1:0]    way_tag,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic [TAG_W-1:0]         mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic                     lru_err
`ifdef VICTIM_SNOOP_EN
  ,
  input  logic [TAG_W-1:0]         snoop_addr,
  output logic                     snoop_hit,
  output logic [DATA_W-1:0]        snoop_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

  occ_t              occ;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic              sel_dirty;
  logic              lru_onehot;
  logic              accept;
  logic              push;
  logic              pop;

  // OR-mux over ways; only meaningful when lru is one-hot, which gates the push.
  always_comb begin
    sel_tag   = '0;
    sel_data  = '0;
    sel_dirty = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (lru[i]) begin
        sel_tag   = sel_tag  | way_tag[i*TAG_W +: TAG_W];
        sel_data  = sel_data | way_data[i*DATA_W +: DATA_W];
        sel_dirty = sel_dirty | dirty[i];
      end
    end
  end

  assign lru_onehot = (lru != '0) && ((lru & (lru - WAYS'(1))) == '0);
  assign accept     = evict_req && evict_ready;
  assign push       = accept && lru_onehot && sel_dirty;
  assign pop        = mem_wr_valid && mem_wr_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);
  end

  // Occupancy state tracks count so the handshake outputs come straight from a register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      occ     <= EMPTY;
      lru_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (count_next == '0)
        occ <= EMPTY;
      else if (count_next == CNT_W'(DEPTH))
        occ <= FULL;
      else
        occ <= PARTIAL;
      if (push) begin
        tag_q[tail]  <= sel_tag;
        data_q[tail] <= sel_data;
        tail         <= tail + PTR_W'(1);
      end
      if (pop)
        head <= head + PTR_W'(1);
      if (accept && !lru_onehot)
        lru_err <= 1'b1;
    end
  end

  assign evict_ready  = (occ != FULL);
  assign mem_wr_valid = (occ != EMPTY);
  assign mem_wr_addr  = tag_q[head];
  assign mem_wr_data  = data_q[head];

`ifdef VICTIM_SNOOP_EN
  logic [PTR_W-1:0] snoop_idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    snoop_hit  = 1'b0;
    snoop_data = '0;
    snoop_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      snoop_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (tag_q[snoop_idx] == snoop_addr)) begin
        snoop_hit  = 1'b1;
        snoop_data = data_q[snoop_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Randomized self-checking bench for victim_wb_buffer against a queue-based reference model.
// Define VICTIM_SNOOP_EN to also exercise the snoop lookup.
module tb_victim_wb_buffer;

  localparam int WAYS   = 4;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 7;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                   clock = 1'b0;
  logic                   resetn;
  logic                   evict_req;
  logic                   evict_ready;
  logic [WAYS-1:0]        lru;
  logic [WAYS-1:0]        dirty;
  logic [WAYS*DATA_W-1:0] way_data;
  logic [WAYS*TAG_W-1:0]  way_tag;
  logic                   mem_wr_valid;
  logic                   mem_wr_ready;
  logic [TAG_W-1:0]       mem_wr_addr;
  logic [DATA_W-1:0]      mem_wr_data;
  logic                   lru_err;
`ifdef VICTIM_SNOOP_EN
  logic [TAG_W-1:0]       snoop_addr;
  logic                   snoop_hit;
  logic [DATA_W-1:0]      snoop_data;
`endif

  entry_t model_q[$];
  logic   model_err;
  int     tests_run  = 0;
  int     fail_count = 0;

  victim_wb_buffer #(.WAYS(WAYS), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .evict_req(evict_req), .evict_ready(evict_ready),
    .lru(lru), .dirty(dirty), .way_data(way_data), .way_tag(way_tag),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .lru_err(lru_err)
`ifdef VICTIM_SNOOP_EN
    , .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    // unused by design: comparisons are inline in each test
  endtask

  // Places the victim at one way and fills the rest with noise.
  task automatic drive_evict(input logic req, input logic [WAYS-1:0] l, input logic [WAYS-1:0] d,
                             input int way, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] dt);
    evict_req = req;
    lru       = l;
    dirty     = d;
    for (int i = 0; i < WAYS; i++) begin
      way_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
      way_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    if (way >= 0) begin
      way_tag[way*TAG_W +: TAG_W]    = t;
      way_data[way*DATA_W +: DATA_W] = dt;
    end
  endtask

  // Compares every output to the model, then advances one clock and updates the model.
  task automatic tick(input string name);
    int     sz;
    logic   acc;
    logic   popd;
    entry_t e;
`ifdef VICTIM_SNOOP_EN
    logic              exp_hit;
    logic [DATA_W-1:0] exp_data;
`endif
    sz = model_q.size();
    tests_run++;
    if (evict_ready !== (sz < DEPTH)) begin
      fail_count++;
      $display("[TB] FAIL %s evict_ready: got %0b required %0b", name, evict_ready, (sz < DEPTH));
    end
    tests_run++;
    if (mem_wr_valid !== (sz != 0)) begin
      fail_count++;
      $display("[TB] FAIL %s mem_wr_valid: got %0b required %0b", name, mem_wr_valid, (sz != 0));
    end
    tests_run++;
    if (lru_err !== model_err) begin
      fail_count++;
      $display("[TB] FAIL %s lru_err: got %0b required %0b", name, lru_err, model_err);
    end
    if (sz != 0) begin
      tests_run++;
      if (mem_wr_addr !== model_q[0].tag || mem_wr_data !== model_q[0].data) begin
        fail_count++;
        $display("[TB] FAIL %s head entry: got addr %h data %h required addr %h data %h",
                 name, mem_wr_addr, mem_wr_data, model_q[0].tag, model_q[0].data);
      end
    end
`ifdef VICTIM_SNOOP_EN
    exp_hit  = 1'b0;
    exp_data = '0;
    foreach (model_q[i]) begin
      if (model_q[i].tag == snoop_addr) begin
        exp_hit  = 1'b1;
        exp_data = model_q[i].data;
      end
    end
    #1;
    tests_run++;
    if (snoop_hit !== exp_hit || (exp_hit && snoop_data !== exp_data)) begin
      fail_count++;
      $display("[TB] FAIL %s snoop %h: got hit %0b data %h required hit %0b data %h",
               name, snoop_addr, snoop_hit, snoop_data, exp_hit, exp_data);
    end
`endif
    acc  = evict_req && (sz < DEPTH);
    popd = (sz != 0) && mem_wr_ready;
    @(posedge clock);
    if (popd)
      void'(model_q.pop_front());
    if (acc) begin
      if ($countones(lru) != 1)
        model_err = 1'b1;
      else
        for (int w = 0; w < WAYS; w++)
          if (lru[w] && dirty[w]) begin
            e.tag  = way_tag[w*TAG_W +: TAG_W];
            e.data = way_data[w*DATA_W +: DATA_W];
            model_q.push_back(e);
          end
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    mem_wr_ready = 1'b0;
`ifdef VICTIM_SNOOP_EN
    snoop_addr = '0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #1;
    model_q.delete();
    model_err = 1'b0;
    tests_run++;
    if (mem_wr_valid !== 1'b0 || evict_ready !== 1'b1 || lru_err !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset flags: got valid %0b ready %0b err %0b required 0 1 0",
               mem_wr_valid, evict_ready, lru_err);
    end
    tests_run++;
    if (mem_wr_addr !== '0 || mem_wr_data !== '0) begin
      fail_count++;
      $display("[TB] FAIL reset head: got addr %h data %h required 0 0", mem_wr_addr, mem_wr_data);
    end
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    tick("reset_idle");
  endtask

  task automatic test_single_dirty();
    mem_wr_ready = 1'b1;
    drive_evict(1'b1, 4'b0010, 4'b0010, 1, 7'h15, 8'hA5);
    tick("single_accept");
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    tests_run++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 7'h15 || mem_wr_data !== 8'hA5) begin
      fail_count++;
      $display("[TB] FAIL single_latency: got valid %0b addr %h data %h required 1 15 a5",
               mem_wr_valid, mem_wr_addr, mem_wr_data);
    end
    tick("single_pop");
    tick("single_empty");
  endtask

  task automatic test_clean_victim();
    drive_evict(1'b1, 4'b0100, 4'b0000, 2, 7'h33, 8'h5C);
    tick("clean_accept");
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    tick("clean_nothing_queued");
  endtask

  task automatic test_fill_drain();
    int budget;
    mem_wr_ready = 1'b0;
    drive_evict(1'b1, 4'b0001, 4'b0001, 0, 7'h01, 8'hC1);
    tick("fill_1");
    drive_evict(1'b1, 4'b1000, 4'b1000, 3, 7'h02, 8'hC2);
    tick("fill_2");
    drive_evict(1'b1, 4'b0010, 4'b0010, 1, 7'h03, 8'hC3);
    tests_run++;
    if (evict_ready !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL fill_stall: got evict_ready %0b required 0", evict_ready);
    end
    for (int i = 0; i < 3; i++)
      tick("fill_stalled");
    mem_wr_ready = 1'b1;
    budget = 0;
    while (model_q.size() != 0 || evict_req) begin
      if (model_q.size() < DEPTH && evict_req) begin
        tick("drain_push3");
        drive_evict(1'b0, '0, '0, -1, '0, '0);
      end else begin
        tick("drain");
      end
      budget++;
      if (budget > 20) begin
        fail_count++;
        $display("[TB] FAIL drain_timeout: got %0d entries left required 0", model_q.size());
        break;
      end
    end
    tick("drain_done");
  endtask

  task automatic test_lru_err();
    mem_wr_ready = 1'b1;
    drive_evict(1'b1, 4'b0110, 4'b0110, 1, 7'h44, 8'h44);
    tick("lru_multi");
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    tests_run++;
    if (lru_err !== 1'b1 || mem_wr_valid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL lru_err_set: got err %0b valid %0b required 1 0", lru_err, mem_wr_valid);
    end
    drive_evict(1'b1, 4'b0001, 4'b0001, 0, 7'h45, 8'h46);
    tick("lru_valid_after");
    drive_evict(1'b1, 4'b0000, 4'b1111, -1, '0, '0);
    tick("lru_zero");
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    for (int i = 0; i < 3; i++)
      tick("lru_sticky");
  endtask

  task automatic test_reset_mid_drain();
    mem_wr_ready = 1'b0;
    drive_evict(1'b1, 4'b0100, 4'b0100, 2, 7'h61, 8'h71);
    tick("rst_fill_1");
    drive_evict(1'b1, 4'b1000, 4'b1000, 3, 7'h62, 8'h72);
    tick("rst_fill_2");
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    mem_wr_ready = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    model_q.delete();
    model_err = 1'b0;
    tests_run++;
    if (mem_wr_valid !== 1'b0 || evict_ready !== 1'b1 || lru_err !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL async_reset: got valid %0b ready %0b err %0b required 0 1 0",
               mem_wr_valid, evict_ready, lru_err);
    end
    @(negedge clock);
    resetn = 1'b1;
    tick("post_reset_1");
    tick("post_reset_2");
  endtask

  task automatic test_random();
    int way;
    for (int n = 0; n < 400; n++) begin
      way = $urandom_range(0, WAYS - 1);
      if ($urandom_range(0, 9) == 0)
        drive_evict($urandom_range(0, 1) == 1, WAYS'($urandom), WAYS'($urandom), -1, '0, '0);
      else
        drive_evict($urandom_range(0, 1) == 1, WAYS'(1) << way, WAYS'($urandom), way,
                    TAG_W'($urandom_range(0, 3)), DATA_W'($urandom));
      mem_wr_ready = ($urandom_range(0, 2) != 0);
`ifdef VICTIM_SNOOP_EN
      snoop_addr = TAG_W'($urandom_range(0, 4));
`endif
      tick("random");
    end
    idle_inputs();
    mem_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++)
      tick("random_flush");
  endtask

`ifdef VICTIM_SNOOP_EN
  task automatic test_snoop();
    mem_wr_ready = 1'b0;
    drive_evict(1'b1, 4'b0001, 4'b0001, 0, 7'h2A, 8'h11);
    tick("snoop_push_1");
    drive_evict(1'b1, 4'b0100, 4'b0100, 2, 7'h2A, 8'h22);
    tick("snoop_push_2");
    drive_evict(1'b0, '0, '0, -1, '0, '0);
    snoop_addr = 7'h2A;
    #1;
    tests_run++;
    if (snoop_hit !== 1'b1 || snoop_data !== 8'h22) begin
      fail_count++;
      $display("[TB] FAIL snoop_youngest: got hit %0b data %h required 1 22", snoop_hit, snoop_data);
    end
    snoop_addr = 7'h00;
    #1;
    tests_run++;
    if (snoop_hit !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL snoop_miss: got hit %0b required 0", snoop_hit);
    end
    mem_wr_ready = 1'b1;
    snoop_addr   = 7'h2A;
    tick("snoop_pop_1");
    tick("snoop_pop_2");
    tick("snoop_empty");
  endtask
`endif

  initial begin
    model_err = 1'b0;
    resetn    = 1'b0;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_single_dirty();
    test_clean_victim();
    test_fill_drain();
    test_lru_err();
    test_reset_mid_drain();
`ifdef VICTIM_SNOOP_EN
    test_snoop();
`endif
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
